// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between the command-port initiator and a register-block target.
// Latency: none, plain wires.
// Backpressure: independent valid/ready per channel (AW, W, B, AR, R).
interface axi4_lite_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns one command into one AXI read or write and returns one response.
// Latency: AXI valids rise the cycle after cmd accept; rsp_valid rises the cycle after the B/R handshake.
// Backpressure: cmd_ready only in IDLE; AXI valids hold until their ready; rsp_* hold until rsp_ready.
module axi4_lite_master #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]  cmd_wstrb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    axi4_lite_master_if.master       axi
);

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RESP
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [DATA_WIDTH-1:0] rdata;
        logic [1:0]            resp;
    } rsp_t;

    state_t state;
    state_t state_nxt;
    rsp_t   rsp_q;

    logic awvalid_nxt;
    logic wvalid_nxt;
    logic arvalid_nxt;
    logic bready_nxt;
    logic rready_nxt;
    logic rsp_vld_nxt;
    logic cmd_acc;
    logic b_cap;
    logic r_cap;
    logic err_hit;

    // Gated by aresetn so the port reads 0 while reset is held, not just after it.
    assign cmd_ready = (state == S_IDLE) && aresetn;

    assign rsp_write = rsp_q.write;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_resp  = rsp_q.resp;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        awvalid_nxt = axi.awvalid;
        wvalid_nxt  = axi.wvalid;
        arvalid_nxt = axi.arvalid;
        bready_nxt  = 1'b0;
        rready_nxt  = 1'b0;
        rsp_vld_nxt = rsp_valid;
        cmd_acc     = 1'b0;
        b_cap       = 1'b0;
        r_cap       = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_acc = 1'b1;
                    if (cmd_write) begin
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = S_WR;
                    end else begin
                        arvalid_nxt = 1'b1;
                        state_nxt   = S_RD_ADDR;
                    end
                end
            end

            S_WR: begin
                // AW and W retire independently; leave once neither is still pending.
                awvalid_nxt = axi.awvalid && !axi.awready;
                wvalid_nxt  = axi.wvalid && !axi.wready;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    bready_nxt = 1'b1;
                    state_nxt  = S_WR_RESP;
                end
            end

            S_WR_RESP: begin
                bready_nxt = 1'b1;
                if (axi.bvalid && axi.bready) begin
                    bready_nxt  = 1'b0;
                    b_cap       = 1'b1;
                    rsp_vld_nxt = 1'b1;
                    state_nxt   = S_RESP;
                end
            end

            S_RD_ADDR: begin
                if (axi.arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = S_RD_DATA;
                end
            end

            S_RD_DATA: begin
                rready_nxt = 1'b1;
                if (axi.rvalid && axi.rready) begin
                    rready_nxt  = 1'b0;
                    r_cap       = 1'b1;
                    rsp_vld_nxt = 1'b1;
                    state_nxt   = S_RESP;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_vld_nxt = 1'b0;
                    state_nxt   = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign err_hit = (b_cap && (axi.bresp != RESP_OKAY)) ||
                     (r_cap && (axi.rresp != RESP_OKAY));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.bready  <= 1'b0;
            axi.rready  <= 1'b0;
            axi.awaddr  <= '0;
            axi.wdata   <= '0;
            axi.wstrb   <= '0;
            axi.araddr  <= '0;
            rsp_valid   <= 1'b0;
            rsp_q       <= '0;
            err_count   <= '0;
        end else begin
            axi.awvalid <= awvalid_nxt;
            axi.wvalid  <= wvalid_nxt;
            axi.arvalid <= arvalid_nxt;
            axi.bready  <= bready_nxt;
            axi.rready  <= rready_nxt;
            rsp_valid   <= rsp_vld_nxt;

            // The AXI address/data registers double as the latched command.
            if (cmd_acc) begin
                if (cmd_write) begin
                    axi.awaddr <= cmd_addr;
                    axi.wdata  <= cmd_wdata;
                    axi.wstrb  <= cmd_wstrb;
                end else begin
                    axi.araddr <= cmd_addr;
                end
            end

            if (b_cap) begin
                rsp_q.write <= 1'b1;
                rsp_q.rdata <= '0;
                rsp_q.resp  <= axi.bresp;
            end

            if (r_cap) begin
                rsp_q.write <= 1'b0;
                rsp_q.rdata <= axi.rdata;
                rsp_q.resp  <= axi.rresp;
            end

            if (err_hit && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master against a 16-register AXI4-Lite target model.
`timescale 1ns/1ps
module tb_axi4_lite_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int EW = 8;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [EW-1:0] err_count;

    always #5 aclk = ~aclk;

    axi4_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .err_count (err_count),
        .axi       (bus)
    );

    // ---------------- target model: 16 word registers at 0x00..0x3C ----------------
    int          aw_delay = 0;
    int          aw_wait;
    logic        aw_got;
    logic        w_got;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] regs [16];

    assign bus.awready = bus.awvalid && !aw_got && (aw_wait >= aw_delay);
    assign bus.wready  = bus.wvalid && !w_got;
    assign bus.arready = bus.arvalid && !bus.rvalid;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a < 32'h40) && (a[1:0] == 2'b00);
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_wait    <= 0;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bus.bvalid <= 1'b0;
            bus.bresp  <= 2'b00;
            bus.rvalid <= 1'b0;
            bus.rresp  <= 2'b00;
            bus.rdata  <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            if (bus.awvalid && !bus.awready && !aw_got) aw_wait <= aw_wait + 1;
            if (bus.awvalid && bus.awready) begin
                aw_got    <= 1'b1;
                aw_addr_q <= bus.awaddr;
                aw_wait   <= 0;
            end
            if (bus.wvalid && bus.wready) begin
                w_got    <= 1'b1;
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrb;
            end
            if (aw_got && w_got && !bus.bvalid) begin
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
                bus.bvalid <= 1'b1;
                if (addr_ok(aw_addr_q)) begin
                    for (int b = 0; b < 4; b++)
                        if (w_strb_q[b]) regs[aw_addr_q[5:2]][8*b +: 8] <= w_data_q[8*b +: 8];
                    bus.bresp <= 2'b00;
                end else begin
                    bus.bresp <= 2'b01;
                end
            end
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (bus.arvalid && bus.arready) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= addr_ok(bus.araddr) ? regs[bus.araddr[5:2]] : 32'h0;
                bus.rresp  <= addr_ok(bus.araddr) ? 2'b00 : 2'b01;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    // ---------------- bus monitors ----------------
    int          awv_cyc = 0;
    int          wv_cyc = 0;
    int          b_hs = 0;
    int          rsp_hs = 0;
    int          rsp_vcyc = 0;
    int          stab_viol = 0;
    logic        aw_pend = 1'b0;
    logic        w_pend = 1'b0;
    logic        ar_pend = 1'b0;
    logic        rsp_pend = 1'b0;
    logic [31:0] aw_prev = '0;
    logic [31:0] w_prev = '0;
    logic [31:0] ar_prev = '0;
    logic [34:0] rsp_prev = '0;

    always @(posedge aclk) begin
        awv_cyc  <= awv_cyc  + int'(bus.awvalid);
        wv_cyc   <= wv_cyc   + int'(bus.wvalid);
        b_hs     <= b_hs     + int'(bus.bvalid && bus.bready);
        rsp_hs   <= rsp_hs   + int'(rsp_valid && rsp_ready);
        rsp_vcyc <= rsp_vcyc + int'(rsp_valid);
        if (!aresetn) begin
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            ar_pend  <= 1'b0;
            rsp_pend <= 1'b0;
        end else begin
            stab_viol <= stab_viol
                + int'(aw_pend  && (!bus.awvalid || bus.awaddr != aw_prev))
                + int'(w_pend   && (!bus.wvalid  || bus.wdata  != w_prev))
                + int'(ar_pend  && (!bus.arvalid || bus.araddr != ar_prev))
                + int'(rsp_pend && (!rsp_valid   || {rsp_write, rsp_resp, rsp_rdata} != rsp_prev));
            aw_pend  <= bus.awvalid && !bus.awready;
            w_pend   <= bus.wvalid && !bus.wready;
            ar_pend  <= bus.arvalid && !bus.arready;
            rsp_pend <= rsp_valid && !rsp_ready;
            aw_prev  <= bus.awaddr;
            w_prev   <= bus.wdata;
            ar_prev  <= bus.araddr;
            rsp_prev <= {rsp_write, rsp_resp, rsp_rdata};
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n = 0;
        @(negedge aclk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!cmd_ready) timeout_fail("cmd_accept");
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (!rsp_valid) timeout_fail("rsp_valid");
    endtask

    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp, output logic [31:0] rdata,
                          output logic rwr, output logic [7:0] ecnt);
        send_cmd(wr, a, d, s);
        wait_rsp();
        resp  = rsp_resp;
        rdata = rsp_rdata;
        rwr   = rsp_write;
        ecnt  = err_count;
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        logic [7:0]  e_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  g_resp;
        logic [31:0] g_rdata;
        logic        g_wr;
        logic [7:0]  g_err;
        int          base_aw;
        int          base_w;
        int          base_b;
        int          base_rsp;
        int          n;

        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        8'd0};
        vecs[1] = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 8'd0};
        vecs[2] = '{1'b1, 32'h10, 32'h11223344, 4'h1, 2'b00, 32'h0,        8'd0};
        vecs[3] = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'hDEADBE44, 8'd0};
        vecs[4] = '{1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 2'b01, 32'h0,        8'd1};
        vecs[5] = '{1'b0, 32'h02, 32'h0,        4'h0, 2'b01, 32'h0,        8'd2};
        vecs[6] = '{1'b1, 32'h3C, 32'hA5A5A5A5, 4'hC, 2'b00, 32'h0,        8'd2};
        vecs[7] = '{1'b0, 32'h3C, 32'h0,        4'h0, 2'b00, 32'hA5A50000, 8'd2};
        vecs[8] = '{1'b1, 32'h04, 32'h0000BEEF, 4'h3, 2'b00, 32'h0,        8'd2};
        vecs[9] = '{1'b0, 32'h04, 32'h0,        4'h0, 2'b00, 32'h0000BEEF, 8'd2};

        // reset state
        #1 aresetn = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid}), 32'h0);
        chk("rst_readies", 32'({bus.bready, bus.rready}), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'h1);

        // table-driven writes/reads, partial strobes, error responses
        for (int i = 0; i < 10; i++) begin
            do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                   g_resp, g_rdata, g_wr, g_err);
            chk($sformatf("vec%0d_resp", i),  32'(g_resp), 32'(vecs[i].e_resp));
            chk($sformatf("vec%0d_rdata", i), g_rdata,     vecs[i].e_rdata);
            chk($sformatf("vec%0d_write", i), 32'(g_wr),   32'(vecs[i].wr));
            chk($sformatf("vec%0d_err", i),   32'(g_err),  32'(vecs[i].e_err));
        end

        // awready 3 cycles late, wready immediate
        aw_delay = 3;
        base_aw  = awv_cyc;
        base_w   = wv_cyc;
        base_b   = b_hs;
        base_rsp = rsp_hs;
        do_cmd(1'b1, 32'h20, 32'h12345678, 4'hF, g_resp, g_rdata, g_wr, g_err);
        repeat (3) @(negedge aclk);
        aw_delay = 0;
        chk("slow_aw_awvalid_cycles", 32'(awv_cyc - base_aw), 32'd4);
        chk("slow_aw_wvalid_cycles",  32'(wv_cyc - base_w),   32'd1);
        chk("slow_aw_b_handshakes",   32'(b_hs - base_b),     32'd1);
        chk("slow_aw_responses",      32'(rsp_hs - base_rsp), 32'd1);
        chk("slow_aw_resp",           32'(g_resp),            32'h0);
        do_cmd(1'b0, 32'h20, 32'h0, 4'h0, g_resp, g_rdata, g_wr, g_err);
        chk("slow_aw_readback", g_rdata, 32'h12345678);

        // response held off by rsp_ready for 5 cycles
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        wait_rsp();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_rsp_valid", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("hold%0d_rdata", k),     rsp_rdata,       32'hDEADBE44);
            chk($sformatf("hold%0d_resp_wr", k),   32'({rsp_write, rsp_resp}), 32'h0);
            chk($sformatf("hold%0d_cmd_ready", k), 32'(cmd_ready), 32'h0);
            if (k < 4) @(negedge aclk);
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        chk("release_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("release_cmd_ready", 32'(cmd_ready), 32'h1);

        // error counter saturation: 300 forced error responses starting from 2
        for (int i = 0; i < 252; i++)
            do_cmd(1'b1, 32'h40, 32'h0, 4'hF, g_resp, g_rdata, g_wr, g_err);
        chk("sat_err_254", 32'(err_count), 32'd254);
        do_cmd(1'b0, 32'h42, 32'h0, 4'h0, g_resp, g_rdata, g_wr, g_err);
        chk("sat_err_255", 32'(err_count), 32'd255);
        for (int i = 0; i < 47; i++)
            do_cmd(1'b1, 32'h80, 32'h0, 4'hF, g_resp, g_rdata, g_wr, g_err);
        chk("sat_err_hold", 32'(err_count), 32'd255);
        chk("sat_last_resp", 32'(g_resp), 32'h1);

        // reset while waiting in WR_RESP
        send_cmd(1'b1, 32'h00, 32'hFFFFFFFF, 4'hF);
        n = 0;
        while (!bus.bready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!bus.bready) timeout_fail("bready");
        base_rsp = rsp_vcyc;
        #2 aresetn = 1'b0;
        #1;
        chk("arst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("arst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid}), 32'h0);
        chk("arst_readies", 32'({bus.bready, bus.rready}), 32'h0);
        chk("arst_err_count", 32'(err_count), 32'h0);
        chk("arst_wdata", bus.wdata, 32'h0);
        chk("arst_addr_strb", 32'({bus.awaddr[7:0], bus.araddr[7:0], bus.wstrb}), 32'h0);
        chk("arst_rsp_fields", 32'({rsp_write, rsp_resp} | {2'b0, |rsp_rdata}), 32'h0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);
        chk("arst_no_response", 32'(rsp_vcyc - base_rsp), 32'h0);
        do_cmd(1'b0, 32'h00, 32'h0, 4'h0, g_resp, g_rdata, g_wr, g_err);
        chk("post_rst_rdata", g_rdata, 32'h0);
        chk("post_rst_resp", 32'(g_resp), 32'h0);
        chk("post_rst_err", 32'(g_err), 32'h0);

        chk("stability_violations", 32'(stab_viol), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
